ram_pipe: RTL and testbench
===========================

// Module: ram_pipe
// PURPOSE
//  Parametrised single-port synchronous RAM; next generation of the 256x64 project RAM.
//  Adds byte-lane write enables, a configurable read latency (1 or 2), a read-valid flag,
//  and hardware memory clearing via a sweep FSM after reset and on request.
//  Sits between the datapath controller and storage; replaces the fixed 256x64 RAM.
// PARAMETERS
//  DATA_W  64   data width in bits; must be a multiple of 8
//  DEPTH   256  number of words; power of two, >= 4
//  ADDR_W  8    address width; equals $clog2(DEPTH)
//  RD_LAT  1    read latency in cycles from the accepted request to s_valid; legal values 1 or 2
// PORTS
//  clk      in   1         rising-edge clock
//  reset_n  in   1         asynchronous reset, active low
//  cen      in   1         chip enable; qualifies a request this cycle
//  wen      in   1         1 = write, 0 = read (meaningful only when cen=1)
//  s_addr   in   ADDR_W    word address
//  s_din    in   DATA_W    write data
//  s_be     in   DATA_W/8  byte-lane write enable; bit i covers s_din[8i+7:8i]
//  clr      in   1         one-cycle pulse: clear all of memory to zero
//  s_dout   out  DATA_W    read data; 0 whenever s_valid=0
//  s_valid  out  1         s_dout carries read data this cycle
//  busy     out  1         clear sweep in progress; requests are ignored
// BEHAVIOUR
//  Reset (reset_n=0, async):
//   - s_dout=0, s_valid=0, busy=1; read pipeline flushed; FSM->CLEAR, sweep counter=0.
//   - Array contents are not reset directly; the sweep zeroes them.
//  FSM states:
//   - CLEAR: writes 0 to mem[cnt] each cycle, cnt++; after writing DEPTH-1 -> READY.
//     busy=1 throughout. busy falls the cycle after the last write, DEPTH cycles after reset release.
//   - READY: busy=0. A clr pulse -> CLEAR with cnt=0. clr in CLEAR is ignored (sweep continues, no restart).
//  Requests (READY only; cen is ignored while busy=1, no queuing):
//   - cen=1, wen=1: on the edge, each lane i with s_be[i]=1 takes s_din lane i; other lanes unchanged.
//     No read occurs; the write produces no s_valid.
//   - cen=1, wen=0: read mem[s_addr].
//     RD_LAT=1: s_dout/s_valid update on the same edge.
//     RD_LAT=2: the edge captures into an internal register; s_dout/s_valid follow one edge later.
//   - cen=0: no access. s_valid drops to 0 and s_dout to 0 when the pipeline drains.
//   - Back-to-back reads every cycle: full throughput, one s_valid per read, in order.
//   - Write then read of the same address on the next cycle returns the new data (write-first ordering).
//   - clr and cen both asserted in READY: clr wins, and the request is dropped.
//     Reads already in the pipeline still complete; no new reads start.
//  Async reset mid-sweep or mid-read: in-flight reads are discarded (s_valid=0); the sweep restarts at 0.
//  Address width: s_addr indexes all DEPTH words; no out-of-range cases exist.
// STRUCTURE
//  Shared package ram_pkg:
//   - FSM state encoding (ST_CLEAR, ST_READY)
//   - RD_LAT legal-value constants
//   - byte-lane count function (DATA_W/8)
//  One sub-module, ram_rd_pipe: the s_dout/s_valid output stage.
//   - Parametrised on DATA_W and RD_LAT.
//   - Async active-low reset; zeroes the data when not valid.
//  Array, write-enable lane merge and sweep FSM live in ram_pipe.
// TESTING
//  1. Release reset; hold cen=1 -> busy=1 for exactly DEPTH cycles, no s_valid. Then read addr 0..DEPTH-1 -> all 0.
//  2. Write addr 8'h10 = 64'hDEAD_BEEF_0123_4567 with s_be=8'hFF, then write 64'hFFFF_FFFF_FFFF_FFFF with s_be=8'h0F.
//     Read 8'h10 -> 64'hDEAD_BEEF_FFFF_FFFF.
//  3. RD_LAT=2, reads of addrs 1,2,3 on consecutive cycles:
//     -> s_valid high on three consecutive cycles starting 2 edges after the first read, data in order.
//     -> s_dout=0 before and after that window.
//  4. Write addr 5 then read addr 5 on the next cycle -> new data. Also apply cen=1, wen=1 alone -> s_valid stays 0.
//  5. Fill addrs 0..3, pulse clr together with a read:
//     -> read dropped; busy high DEPTH cycles; addrs 0..3 then read back 0.
//  6. Assert reset_n=0 asynchronously mid-sweep and during an RD_LAT=2 read:
//     -> s_valid/s_dout go to 0 immediately; after release, busy lasts a full DEPTH cycles.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared constants for the pipelined RAM slice.
// State encoding, read-latency limits, lane count.
package ram_pkg;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    function automatic int lane_cnt(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Read output stage of ram_pipe.
// One or two register stages; data forced to 0 when not valid.
module ram_rd_pipe
    import ram_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rd_en_i,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o
);

    logic              v1_q;
    logic [DATA_W-1:0] d1_q;

    // First stage: capture the array word on an accepted read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1_q <= 1'b0;
            d1_q <= '0;
        end else begin
            v1_q <= rd_en_i;
            d1_q <= rd_en_i ? rd_data_i : '0;
        end
    end

    if (RD_LAT >= RD_LAT_MAX) begin : g_lat2
        logic              v2_q;
        logic [DATA_W-1:0] d2_q;

        // Second stage: plain delay; first stage already zeroes idle data.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                v2_q <= 1'b0;
                d2_q <= '0;
            end else begin
                v2_q <= v1_q;
                d2_q <= d1_q;
            end
        end

        assign valid_o = v2_q;
        assign data_o  = d2_q;
    end else begin : g_lat1
        assign valid_o = v1_q;
        assign data_o  = d1_q;
    end

endmodule

// File: rtl/ram_pipe.sv
// Single-port RAM with byte lanes, 1/2-cycle reads
// and a zeroing sweep after reset or on clr.
module ram_pipe
    import ram_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cen,
    input  logic                wen,
    input  logic [ADDR_W-1:0]   s_addr,
    input  logic [DATA_W-1:0]   s_din,
    input  logic [DATA_W/8-1:0] s_be,
    input  logic                clr,
    output logic [DATA_W-1:0]   s_dout,
    output logic                s_valid,
    output logic                busy
);

    localparam int NB = lane_cnt(DATA_W);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    logic              ready;
    logic              req;
    logic              rd_en;
    logic              wr_en;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] wr_word;

    // clr takes priority over a same-cycle request
    assign ready   = (state_q == ST_READY);
    assign req     = ready & cen & ~clr;
    assign rd_en   = req & ~wen;
    assign wr_en   = req & wen;
    assign busy    = ~ready;
    assign rd_word = mem_q[s_addr];

    // Sweep FSM: walk every address once, then idle until clr.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (clr) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state and sweep counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Byte-lane merge of new data over the stored word.
    always_comb begin
        wr_word = rd_word;
        for (int i = 0; i < NB; i++) begin
            if (s_be[i]) begin
                wr_word[8*i +: 8] = s_din[8*i +: 8];
            end
        end
    end

    // Array write port: sweep zeroes, otherwise merged request data.
    always_ff @(posedge clk) begin
        if (!ready && reset_n) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_en) begin
            mem_q[s_addr] <= wr_word;
        end
    end

    ram_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .rd_en_i   (rd_en),
        .rd_data_i (rd_word),
        .data_o    (s_dout),
        .valid_o   (s_valid)
    );

endmodule

// File: tb/tb_ram_pipe.sv
// Bench for ram_pipe: latency-1 and latency-2 instances
// share stimulus; per-instance scoreboards check reads.
module tb_ram_pipe;

    localparam int DW    = 64;
    localparam int DEPTH = 256;
    localparam int AW    = 8;

    typedef struct {
        logic [DW-1:0] d;
        int            due;
    } exp_t;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic [7:0]    be;
        logic [DW-1:0] exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cen = 1'b0;
    logic          wen = 1'b0;
    logic          clr = 1'b0;
    logic [AW-1:0] s_addr = '0;
    logic [DW-1:0] s_din = '0;
    logic [7:0]    s_be = '0;

    logic [DW-1:0] dout1, dout2;
    logic          v1, v2, busy1, busy2;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    logic mon_en  = 1'b0;

    exp_t          q[2][$];
    logic [DW-1:0] mdl [DEPTH];
    vec_t          tbl [8];

    ram_pipe #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .RD_LAT(1)) u1 (
        .clk(clk), .reset_n(reset_n), .cen(cen), .wen(wen),
        .s_addr(s_addr), .s_din(s_din), .s_be(s_be), .clr(clr),
        .s_dout(dout1), .s_valid(v1), .busy(busy1)
    );

    ram_pipe #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .RD_LAT(2)) u2 (
        .clk(clk), .reset_n(reset_n), .cen(cen), .wen(wen),
        .s_addr(s_addr), .s_din(s_din), .s_be(s_be), .clr(clr),
        .s_dout(dout2), .s_valid(v2), .busy(busy2)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mon(input int k, input logic v, input logic [DW-1:0] d);
        exp_t e;
        n_tests++;
        if (v) begin
            if (q[k].size() == 0) begin
                n_fail++;
                $display("FAIL lat%0d unexpected valid: got %h at cyc %0d expected none",
                         k + 1, d, cyc);
            end else begin
                e = q[k].pop_front();
                if (d !== e.d || cyc != e.due) begin
                    n_fail++;
                    $display("FAIL lat%0d read: got %h at cyc %0d expected %h at cyc %0d",
                             k + 1, d, cyc, e.d, e.due);
                end
            end
        end else begin
            if (d !== '0) begin
                n_fail++;
                $display("FAIL lat%0d idle dout: got %h expected 0", k + 1, d);
            end
            if (q[k].size() > 0 && q[k][0].due <= cyc) begin
                n_fail++;
                $display("FAIL lat%0d missing valid: got none expected %h at cyc %0d",
                         k + 1, q[k][0].d, q[k][0].due);
                void'(q[k].pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0, v1, dout1);
            mon(1, v2, dout2);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        q[0].delete();
        q[1].delete();
    endtask

    task automatic push(input logic [DW-1:0] d);
        exp_t e;
        e.d   = d;
        e.due = cyc + 1;
        q[0].push_back(e);
        e.due = cyc + 2;
        q[1].push_back(e);
    endtask

    task automatic idle();
        cen = 1'b0;
        wen = 1'b0;
        clr = 1'b0;
        tick();
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [7:0] be);
        cen = 1'b1;
        wen = 1'b1;
        clr = 1'b0;
        s_addr = a;
        s_din = d;
        s_be = be;
        for (int i = 0; i < 8; i++)
            if (be[i]) mdl[a][8*i +: 8] = d[8*i +: 8];
        tick();
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        cen = 1'b1;
        wen = 1'b0;
        clr = 1'b0;
        s_addr = a;
        push(exp);
        tick();
    endtask

    task automatic wait_ready(input string name);
        int n1 = 0;
        int n2 = 0;
        for (int i = 0; i < 2 * DEPTH + 8; i++) begin
            @(negedge clk);
            if (busy1) n1++;
            if (busy2) n2++;
            if (!busy1 && !busy2) break;
        end
        cen = 1'b0;
        clr = 1'b0;
        chk({name, " busy cycles lat1"}, DW'(n1), DW'(DEPTH));
        chk({name, " busy cycles lat2"}, DW'(n2), DW'(DEPTH));
    endtask

    initial begin
        tbl[0] = '{1'b1, 8'h10, 64'hDEAD_BEEF_0123_4567, 8'hFF, 64'h0};
        tbl[1] = '{1'b1, 8'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 64'h0};
        tbl[2] = '{1'b0, 8'h10, 64'h0, 8'h00, 64'hDEAD_BEEF_FFFF_FFFF};
        tbl[3] = '{1'b1, 8'h05, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0};
        tbl[4] = '{1'b0, 8'h05, 64'h0, 8'h00, 64'h0123_4567_89AB_CDEF};
        tbl[5] = '{1'b1, 8'h20, 64'h1111_2222_3333_4444, 8'hA5, 64'h0};
        tbl[6] = '{1'b0, 8'h20, 64'h0, 8'h00, 64'h1100_2200_0033_0044};
        tbl[7] = '{1'b0, 8'h21, 64'h0, 8'h00, 64'h0};
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;

        // reset state, then sweep with a read held on cen
        cen = 1'b1;
        tick();
        tick();
        mon_en = 1'b1;
        chk("reset s_valid lat1", DW'(v1), 64'h0);
        chk("reset s_valid lat2", DW'(v2), 64'h0);
        chk("reset s_dout lat2", dout2, 64'h0);
        chk("reset busy", DW'({busy1, busy2}), 64'h3);
        reset_n = 1'b1;
        wait_ready("init");
        for (int i = 0; i < DEPTH; i++) rd(AW'(i), 64'h0);
        repeat (3) idle();

        // table of writes / reads, back to back
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].wr) wr(tbl[i].addr, tbl[i].din, tbl[i].be);
            else rd(tbl[i].addr, tbl[i].exp);
        end
        repeat (3) idle();

        // consecutive reads 1,2,3
        wr(8'h01, 64'hA1A1_0000_0000_0001, 8'hFF);
        wr(8'h02, 64'hB2B2_0000_0000_0002, 8'hFF);
        wr(8'h03, 64'hC3C3_0000_0000_0003, 8'hFF);
        idle();
        rd(8'h01, mdl[1]);
        rd(8'h02, mdl[2]);
        rd(8'h03, mdl[3]);
        repeat (4) idle();

        // write alone yields no valid
        wr(8'h30, 64'h5555_5555_5555_5555, 8'hFF);
        cen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("write-only valid", DW'({v1, v2}), 64'h0);
        end

        // clr with a read: in-flight read completes, new one dropped
        for (int i = 0; i < 4; i++) wr(AW'(i), 64'h0F0F_0000_0000_0000 | DW'(i + 1), 8'hFF);
        rd(8'h03, mdl[3]);
        cen = 1'b1;
        wen = 1'b0;
        clr = 1'b1;
        s_addr = 8'h00;
        tick();
        cen = 1'b0;
        clr = 1'b0;
        wait_ready("clr");
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        for (int i = 0; i < 4; i++) rd(AW'(i), 64'h0);
        repeat (3) idle();

        // async reset during a read
        wr(8'h09, 64'h9999_8888_7777_6666, 8'hFF);
        rd(8'h09, mdl[9]);
        cen = 1'b0;
        chk("lat1 valid before reset", DW'(v1), 64'h1);
        reset_n = 1'b0;
        flush();
        #1;
        chk("async rst valid", DW'({v1, v2}), 64'h0);
        chk("async rst dout lat1", dout1, 64'h0);
        chk("async rst dout lat2", dout2, 64'h0);
        tick();
        reset_n = 1'b1;
        repeat (10) tick();
        chk("mid-sweep busy", DW'({busy1, busy2}), 64'h3);
        reset_n = 1'b0;
        #1;
        chk("mid-sweep rst busy", DW'({busy1, busy2}), 64'h3);
        tick();
        reset_n = 1'b1;
        wait_ready("rst");
        rd(8'h09, 64'h0);
        repeat (4) idle();

        chk("lat1 queue drained", DW'(q[0].size()), 64'h0);
        chk("lat2 queue drained", DW'(q[1].size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
